// File: rtl/vector_issue_sequencer_if.sv
// Issue-stage bus: the instruction handshake from vector decode, the beat
// handshake toward the execute lanes, and the status pulses.
interface vector_issue_sequencer_if #(
  parameter int OPCODE_W = 5,
  parameter int ALUOP_W  = 4,
  parameter int VLEN     = 16,
  parameter int LANES    = 4,
  parameter int VL_W     = $clog2(VLEN + 1)
);
  localparam int EB_W = (VLEN > 1) ? $clog2(VLEN) : 1;

  logic                in_valid;
  logic                in_ready;
  logic [OPCODE_W-1:0] in_opcode;
  logic [VL_W-1:0]     in_vl;
  logic                out_valid;
  logic                out_ready;
  logic                out_regdst;
  logic                out_memtoreg;
  logic                out_regwrite;
  logic                out_memread;
  logic                out_memwrite;
  logic                out_tipo;
  logic [ALUOP_W-1:0]  out_aluop;
  logic [EB_W-1:0]     out_elem_base;
  logic [LANES-1:0]    out_lane_mask;
  logic                out_last;
  logic                illegal_op;
  logic                busy;

  // Upstream decode plus the execute lanes' ready.
  modport master (
    output in_valid, in_opcode, in_vl, out_ready,
    input  in_ready, out_valid, out_regdst, out_memtoreg, out_regwrite,
           out_memread, out_memwrite, out_tipo, out_aluop, out_elem_base,
           out_lane_mask, out_last, illegal_op, busy
  );

  // The sequencer itself.
  modport slave (
    input  in_valid, in_opcode, in_vl, out_ready,
    output in_ready, out_valid, out_regdst, out_memtoreg, out_regwrite,
           out_memread, out_memwrite, out_tipo, out_aluop, out_elem_base,
           out_lane_mask, out_last, illegal_op, busy
  );
endinterface

// File: rtl/vector_issue_sequencer.sv
// Vector issue stage: decodes one vector opcode per accept and plays it out
// as LANES-wide beats with element base, lane mask and last flag.
module vector_issue_sequencer #(
  parameter int OPCODE_W = 5,
  parameter int ALUOP_W  = 4,
  parameter int VLEN     = 16,
  parameter int LANES    = 4,
  parameter int VL_W     = $clog2(VLEN + 1)
) (
  input logic                     clk,
  input logic                     rst_n,
  vector_issue_sequencer_if.slave bus
);
  localparam int EB_W = (VLEN > 1) ? $clog2(VLEN) : 1;
  // One extra bit so base + LANES never overflows in the beat arithmetic.
  localparam int CW   = VL_W + 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  typedef struct packed {
    logic               legal;
    logic               regdst;
    logic               memtoreg;
    logic               regwrite;
    logic               memread;
    logic               memwrite;
    logic [ALUOP_W-1:0] aluop;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [OPCODE_W-1:0] op);
    decode = '0;
    case (op)
      OPCODE_W'(5'b00010): decode = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ALUOP_W'(1)};
      OPCODE_W'(5'b10001): decode = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ALUOP_W'(4)};
      OPCODE_W'(5'b00110): decode = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ALUOP_W'(2)};
      OPCODE_W'(5'b00100): decode = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ALUOP_W'(3)};
      OPCODE_W'(5'b01110): decode = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ALUOP_W'(0)};
      OPCODE_W'(5'b10000): decode = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_W'(0)};
      OPCODE_W'(5'b01001): decode = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ALUOP_W'(5)};
      OPCODE_W'(5'b01010): decode = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ALUOP_W'(6)};
      OPCODE_W'(5'b00111): decode = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ALUOP_W'(7)};
      OPCODE_W'(5'b01000): decode = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ALUOP_W'(8)};
      default:             decode = '0;
    endcase
  endfunction

  function automatic logic [LANES-1:0] mask_for(input logic [CW-1:0] base,
                                                input logic [CW-1:0] vl);
    for (int i = 0; i < LANES; i++) begin
      mask_for[i] = (base + CW'(i)) < vl;
    end
  endfunction

  state_t            state, state_n;
  ctrl_t             dec;
  ctrl_t             ctrl_p0;
  logic [VL_W-1:0]   vl_eff;
  logic [VL_W-1:0]   vl_p0;
  logic [EB_W-1:0]   base_p0;
  logic [LANES-1:0]  mask_p0;
  logic              last_p0;
  logic              ill_p0;
  logic [CW-1:0]     base_nxt;
  logic              accept;
  logic              new_ok;
  logic              load_new;
  logic              advance;

  assign dec      = decode(bus.in_opcode);
  assign vl_eff   = (bus.in_vl > VL_W'(VLEN)) ? VL_W'(VLEN) : bus.in_vl;
  assign new_ok   = dec.legal && (vl_eff != '0);
  assign base_nxt = CW'(base_p0) + CW'(LANES);

  // A new instruction may enter when idle, or on the cycle its predecessor's
  // final beat is taken, which gives back-to-back issue without a bubble.
  assign bus.in_ready = rst_n && ((state == IDLE) || (bus.out_ready && last_p0));
  assign accept       = bus.in_valid && bus.in_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state: load a fresh beat 0 or step to the following beat.
  always_comb begin
    state_n  = state;
    load_new = 1'b0;
    advance  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept && new_ok) begin
          load_new = 1'b1;
          state_n  = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.out_ready) begin
          if (last_p0) begin
            if (accept && new_ok) load_new = 1'b1;
            else                  state_n  = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // ---- stage p0: beat register presented to the execute lanes ----
  // Beat contents; held while the lanes stall, cleared by reset so no
  // stale beat survives an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_p0 <= '0;
      vl_p0   <= '0;
      base_p0 <= '0;
      mask_p0 <= '0;
      last_p0 <= 1'b0;
      ill_p0  <= 1'b0;
    end else begin
      ill_p0 <= accept && !dec.legal;
      if (load_new) begin
        ctrl_p0 <= dec;
        vl_p0   <= vl_eff;
        base_p0 <= '0;
        mask_p0 <= mask_for('0, CW'(vl_eff));
        last_p0 <= CW'(LANES) >= CW'(vl_eff);
      end else if (advance) begin
        base_p0 <= base_nxt[EB_W-1:0];
        mask_p0 <= mask_for(base_nxt, CW'(vl_p0));
        last_p0 <= (base_nxt + CW'(LANES)) >= CW'(vl_p0);
      end
    end
  end

  assign bus.out_valid     = (state == ISSUE);
  assign bus.busy          = (state == ISSUE);
  assign bus.out_regdst    = ctrl_p0.regdst;
  assign bus.out_memtoreg  = ctrl_p0.memtoreg;
  assign bus.out_regwrite  = ctrl_p0.regwrite;
  assign bus.out_memread   = ctrl_p0.memread;
  assign bus.out_memwrite  = ctrl_p0.memwrite;
  // Every vector op sets tipo, so it is simply the loaded-legal flag.
  assign bus.out_tipo      = ctrl_p0.legal;
  assign bus.out_aluop     = ctrl_p0.aluop;
  assign bus.out_elem_base = base_p0;
  assign bus.out_lane_mask = mask_p0;
  assign bus.out_last      = last_p0;
  assign bus.illegal_op    = ill_p0;
endmodule

// File: tb/tb_vector_issue_sequencer.sv
// Bench for vector_issue_sequencer: a beat-queue model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_vector_issue_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_issue_sequencer_if bus ();

  vector_issue_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  typedef struct {
    bit legal;
    bit regdst, memtoreg, regwrite, memread, memwrite;
    int aluop;
  } dec_t;

  typedef struct {
    int   base;
    int   mask;
    bit   last;
    dec_t d;
  } beat_t;

  function automatic dec_t ref_decode(input int op);
    dec_t d;
    d = '{0, 0, 0, 0, 0, 0, 0};
    case (op)
      2:  d = '{1, 1, 0, 1, 0, 0, 1};
      17: d = '{1, 1, 0, 1, 0, 0, 4};
      6:  d = '{1, 0, 0, 1, 0, 0, 2};
      4:  d = '{1, 0, 0, 1, 0, 0, 3};
      14: d = '{1, 0, 1, 1, 1, 0, 0};
      16: d = '{1, 0, 0, 0, 0, 1, 0};
      9:  d = '{1, 1, 0, 1, 0, 0, 5};
      10: d = '{1, 1, 0, 1, 0, 0, 6};
      7:  d = '{1, 1, 0, 1, 0, 0, 7};
      8:  d = '{1, 1, 0, 1, 0, 0, 8};
      default: d = '{0, 0, 0, 0, 0, 0, 0};
    endcase
    return d;
  endfunction

  // Outstanding beats the DUT still owes, front = beat currently expected.
  beat_t q[$];
  bit    exp_ill = 0;

  task automatic push_instr(input int op, input int vl);
    dec_t  d;
    beat_t b;
    int    vle, nb;
    d   = ref_decode(op);
    vle = (vl > 16) ? 16 : vl;
    if (d.legal && vle > 0) begin
      nb = (vle + 3) / 4;
      for (int k = 0; k < nb; k++) begin
        b.base = k * 4;
        b.mask = 0;
        for (int i = 0; i < 4; i++)
          if (b.base + i < vle) b.mask |= (1 << i);
        b.last = (k == nb - 1);
        b.d    = d;
        q.push_back(b);
      end
    end
  endtask

  // Every-cycle comparison against the model; inputs are stable at negedge.
  always @(negedge clk) begin
    bit rdy, acc, nonempty;
    if (!rst_n) begin
      q.delete();
      exp_ill = 0;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_illegal", bus.illegal_op, 0);
    end else begin
      nonempty = (q.size() != 0);
      rdy = !nonempty || (bus.out_ready && q[0].last);
      chk("m_in_ready", bus.in_ready, rdy);
      chk("m_out_valid", bus.out_valid, nonempty);
      chk("m_busy", bus.busy, nonempty);
      chk("m_illegal", bus.illegal_op, exp_ill);
      if (nonempty && bus.out_valid) begin
        chk("m_base", bus.out_elem_base, q[0].base);
        chk("m_mask", bus.out_lane_mask, q[0].mask);
        chk("m_last", bus.out_last, q[0].last);
        chk("m_aluop", bus.out_aluop, q[0].d.aluop);
        chk("m_regdst", bus.out_regdst, q[0].d.regdst);
        chk("m_memtoreg", bus.out_memtoreg, q[0].d.memtoreg);
        chk("m_regwrite", bus.out_regwrite, q[0].d.regwrite);
        chk("m_memread", bus.out_memread, q[0].d.memread);
        chk("m_memwrite", bus.out_memwrite, q[0].d.memwrite);
        chk("m_tipo", bus.out_tipo, 1);
      end
      acc = bus.in_valid && rdy;
      if (nonempty && bus.out_ready) void'(q.pop_front());
      exp_ill = acc && !ref_decode(int'(bus.in_opcode)).legal;
      if (acc) push_instr(int'(bus.in_opcode), int'(bus.in_vl));
    end
  end

  task automatic send(input logic [4:0] op, input int vl);
    bit ok;
    ok = 0;
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_vl     = 5'(vl);
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1;
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!bus.out_valid) done = 1;
    end
    if (!done) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bit done;
    bus.in_valid  = 1'b0;
    bus.in_opcode = '0;
    bus.in_vl     = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", bus.out_valid, 0);
    chk("reset_base", bus.out_elem_base, 0);
    chk("reset_mask", bus.out_lane_mask, 0);
    chk("reset_aluop", bus.out_aluop, 0);
    chk("reset_regwrite", bus.out_regwrite, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_in_ready", bus.in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // ADDV, vl=16: four full beats
    send(5'b00010, 16);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("addv_base", bus.out_elem_base, k * 4);
      chk("addv_mask", bus.out_lane_mask, 15);
      chk("addv_last", bus.out_last, (k == 3) ? 1 : 0);
      chk("addv_aluop", bus.out_aluop, 1);
      chk("addv_regdst", bus.out_regdst, 1);
      chk("addv_regwrite", bus.out_regwrite, 1);
    end
    wait_idle();

    // LOADV, vl=6: full beat then partial
    send(5'b01110, 6);
    @(negedge clk);
    chk("loadv_mask0", bus.out_lane_mask, 15);
    chk("loadv_memread", bus.out_memread, 1);
    chk("loadv_memtoreg", bus.out_memtoreg, 1);
    chk("loadv_last0", bus.out_last, 0);
    @(negedge clk);
    chk("loadv_mask1", bus.out_lane_mask, 3);
    chk("loadv_last1", bus.out_last, 1);
    wait_idle();

    // LOADV, vl=20 clamps to 16
    send(5'b01110, 20);
    n = 0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        n++;
        if (bus.out_last) done = 1;
      end
    end
    chk("clamp_beats", n, 4);
    wait_idle();

    // STOREV, vl=8 with a 3-cycle stall on beat 0
    bus.out_ready = 1'b0;
    send(5'b10000, 8);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_base", bus.out_elem_base, 0);
      chk("stall_mask", bus.out_lane_mask, 15);
      chk("stall_memwrite", bus.out_memwrite, 1);
      chk("stall_regwrite", bus.out_regwrite, 0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_base0", bus.out_elem_base, 0);
    @(negedge clk);
    chk("stall_beat1_base", bus.out_elem_base, 4);
    chk("stall_beat1_last", bus.out_last, 1);
    wait_idle();

    // SUBV vl=4 then RORV vl=4 with no bubble
    send(5'b10001, 4);
    chk("subv_aluop", bus.out_aluop, 4);
    chk("subv_last", bus.out_last, 1);
    send(5'b00111, 4);
    chk("rorv_valid", bus.out_valid, 1);
    chk("rorv_aluop", bus.out_aluop, 7);
    chk("rorv_base", bus.out_elem_base, 0);
    wait_idle();

    // Unknown opcode: single illegal_op pulse, no beat
    send(5'b11111, 4);
    chk("ill_pulse", bus.illegal_op, 1);
    chk("ill_no_beat", bus.out_valid, 0);
    chk("ill_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    chk("ill_pulse_end", bus.illegal_op, 0);
    chk("ill_no_beat2", bus.out_valid, 0);

    // MOVV vl=0: nothing issued, no pulse
    send(5'b00100, 0);
    chk("vl0_no_pulse", bus.illegal_op, 0);
    chk("vl0_no_beat", bus.out_valid, 0);
    @(posedge clk);
    #1;
    chk("vl0_no_beat2", bus.out_valid, 0);

    // XORIV vl=16, reset during beat 2
    send(5'b00110, 16);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("xoriv_beat2_base", bus.out_elem_base, 8);
    chk("xoriv_aluop", bus.out_aluop, 2);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_base", bus.out_elem_base, 0);
    chk("abort_mask", bus.out_lane_mask, 0);
    chk("abort_aluop", bus.out_aluop, 0);
    chk("abort_regwrite", bus.out_regwrite, 0);
    chk("abort_tipo", bus.out_tipo, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_in_ready", bus.in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready_after", bus.in_ready, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_no_stale", bus.out_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end
endmodule
